// File: rtl/fft_result_streamer_pkg.sv
// Shared definitions for the FFT result streamer: default frame geometry,
// the streamer state encoding and the bin index bit-reversal helper.
package fft_result_streamer_pkg;

  // Default frame geometry: number of FFT points and sample width.
  localparam int N_DEF     = 16;
  localparam int W_DEF     = 16;
  // Width of a bin index for the default frame size.
  localparam int IDX_W_DEF = $clog2(N_DEF);

  // Streamer states: waiting for a frame, or delivering one.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Reverse the low 'bits' bits of idx; bits above 'bits' come back zero.
  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) begin
      if (idx[b]) begin
        r = r | (1 << (bits - 1 - b));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_index.sv
// Combinational bin index reversal, used when bins are streamed in
// bit-reversed order.
module fft_bitrev_index
  import fft_result_streamer_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] rev
);

  // Mirror the index bits around the centre of the IDX_W-bit field.
  assign rev = IDX_W'(bitrev(int'(idx), IDX_W));

endmodule

// File: rtl/fft_result_streamer.sv
// Captures a full parallel FFT result on the rising edge of fft_done and
// streams it out one bin per accepted word over a valid/ready interface.
// Supports back-to-back frames when a new result arrives exactly as the
// final word of the current frame is accepted; any other overlapping
// result is discarded and flagged in the sticky drop_err.
module fft_result_streamer
  import fft_result_streamer_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int W      = W_DEF,
  parameter  int BITREV = 0,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_done,
  input  logic [N*W-1:0]   in_real,
  input  logic [N*W-1:0]   in_imag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_real,
  output logic [W-1:0]     m_imag,
  output logic [IDX_W-1:0] m_index,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done,
  output logic             drop_err
);

  state_t           state;
  state_t           state_nxt;

  logic             done_q;     // fft_done as seen last cycle
  logic             armed;      // fft_done has been seen low since reset
  logic             done_edge;  // a new frame is being offered this cycle

  logic             xfer;       // a word is accepted this cycle
  logic             last_xfer;  // the final word of the frame is accepted
  logic             load;       // capture the offered frame this cycle
  logic             advance;    // step to the next word of the current frame

  logic [IDX_W-1:0] cnt;        // transfer count of the word on the bus
  logic [IDX_W-1:0] k_nxt;      // transfer count of the next word to present
  logic [IDX_W-1:0] sel_idx;    // buffer index holding that next word

  logic [W-1:0]     in_re_w [N];
  logic [W-1:0]     in_im_w [N];
  logic [W-1:0]     buf_re  [N];
  logic [W-1:0]     buf_im  [N];

  // Present the flat input buses as per-bin words.
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign in_re_w[g] = in_real[g*W +: W];
    assign in_im_w[g] = in_imag[g*W +: W];
  end

  // A frame counts only on a genuine low-to-high transition observed after
  // reset, so a level still high from before reset cannot trigger a stream.
  assign done_edge = armed & fft_done & ~done_q;

  assign m_valid   = (state == ST_STREAM);
  assign busy      = (state == ST_STREAM);

  assign xfer      = m_valid & m_ready;
  assign last_xfer = xfer & m_last;
  // A new frame is taken when idle, or when it lands exactly on the final
  // accepted word so the stream continues without a bubble.
  assign load      = done_edge & ((state == ST_IDLE) | last_xfer);
  assign advance   = xfer & ~m_last;
  assign k_nxt     = load ? '0 : cnt + IDX_W'(1);

  // Map the next transfer count onto the buffer slot it should read.
  if (BITREV != 0) begin : g_rev
    fft_bitrev_index #(
      .IDX_W (IDX_W)
    ) u_bitrev_index (
      .idx (k_nxt),
      .rev (sel_idx)
    );
  end else begin : g_nat
    assign sel_idx = k_nxt;
  end

  // Track the previous fft_done level and arm edge detection once it is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      done_q <= fft_done;
      if (!fft_done) begin
        armed <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision: enter STREAM on a capture, leave after the final
  // word unless a back-to-back frame was captured on that same cycle.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_nxt.
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_xfer && !load) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame buffer: snapshot all bins when a frame is taken.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately left out of reset; its contents are
    // only read after a capture has overwritten every entry.
    if (load) begin
      for (int i = 0; i < N; i++) begin
        buf_re[i] <= in_re_w[i];
        buf_im[i] <= in_im_w[i];
      end
    end
  end

  // Output word register and status flags. On a capture the first word is
  // taken straight from the inputs, since the buffer is filled on the same
  // edge; afterwards words come from the buffer selected by the counter.
  // Nothing updates while a word is waiting for acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      m_real     <= '0;
      m_imag     <= '0;
      m_index    <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      frame_done <= last_xfer & ~load;

      if (done_edge && (state == ST_STREAM) && !last_xfer) begin
        drop_err <= 1'b1;
      end

      if (load || advance) begin
        cnt     <= k_nxt;
        m_index <= sel_idx;
        m_last  <= (k_nxt == IDX_W'(N - 1));
        if (load) begin
          m_real <= in_re_w[sel_idx];
          m_imag <= in_im_w[sel_idx];
        end else begin
          m_real <= buf_re[sel_idx];
          m_imag <= buf_im[sel_idx];
        end
      end else if (last_xfer) begin
        m_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Self-checking bench for fft_result_streamer. Two instances share all
// stimulus: one streams in natural order, one in bit-reversed order. Each
// offered frame pushes its expected words into a per-instance queue; a
// monitor pops and compares on every accepted word and checks that words
// hold steady while stalled.
module tb_fft_result_streamer;

  localparam int N = 16;
  localparam int W = 16;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
    logic        last;
  } word_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fft_done = 1'b0;
  logic           m_ready = 1'b0;
  logic [N*W-1:0] in_real = '0;
  logic [N*W-1:0] in_imag = '0;

  logic           m_valid0, m_last0, busy0, frame_done0, drop_err0;
  logic [W-1:0]   m_real0, m_imag0;
  logic [3:0]     m_index0;
  logic           m_valid1, m_last1, busy1, frame_done1, drop_err1;
  logic [W-1:0]   m_real1, m_imag1;
  logic [3:0]     m_index1;

  int             n_checks = 0;
  int             n_errors = 0;
  word_t          q0[$];
  word_t          q1[$];
  int             xfer0 = 0;
  int             fd0 = 0;
  logic           hold_v[2] = '{1'b0, 1'b0};
  word_t          hold_w[2];
  logic [15:0]    fr_re[N];
  logic [15:0]    fr_im[N];
  int             rev_order[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_result_streamer #(.N(N), .W(W), .BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .in_real(in_real), .in_imag(in_imag),
    .m_valid(m_valid0), .m_ready(m_ready),
    .m_real(m_real0), .m_imag(m_imag0), .m_index(m_index0), .m_last(m_last0),
    .busy(busy0), .frame_done(frame_done0), .drop_err(drop_err0)
  );

  fft_result_streamer #(.N(N), .W(W), .BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .in_real(in_real), .in_imag(in_imag),
    .m_valid(m_valid1), .m_ready(m_ready),
    .m_real(m_real1), .m_imag(m_imag1), .m_index(m_index1), .m_last(m_last1),
    .busy(busy1), .frame_done(frame_done1), .drop_err(drop_err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input word_t cur);
    word_t exp;
    int    qs;
    if (hold_v[id]) begin
      check($sformatf("stall_valid%0d", id), v, 1);
      check($sformatf("stall_hold%0d", id), cur, hold_w[id]);
    end
    if (v && m_ready) begin
      qs = (id == 0) ? q0.size() : q1.size();
      check($sformatf("word_expected%0d", id), qs > 0, 1);
      if (qs > 0) begin
        if (id == 0) exp = q0.pop_front();
        else         exp = q1.pop_front();
        check($sformatf("word%0d", id), cur, exp);
      end
    end
    hold_v[id] = v && !m_ready;
    hold_w[id] = cur;
  endtask

  // Scoreboard side: compare every accepted word, count transfers and pulses.
  always @(negedge clk) begin
    if (!rst) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      mon(0, m_valid0, '{re: m_real0, im: m_imag0, idx: m_index0, last: m_last0});
      mon(1, m_valid1, '{re: m_real1, im: m_imag1, idx: m_index1, last: m_last1});
      if (m_valid0 && m_ready) xfer0++;
      if (frame_done0) fd0++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'(i);
      fr_im[i] = 16'(-i);
    end
  endtask

  task automatic load_const(input logic [15:0] re, input logic [15:0] im);
    for (int i = 0; i < N; i++) begin
      fr_re[i] = re;
      fr_im[i] = im;
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < N; i++) begin
      fr_re[i] = 16'($urandom);
      fr_im[i] = 16'($urandom);
    end
  endtask

  task automatic drive_frame();
    for (int i = 0; i < N; i++) begin
      in_real[i*W +: W] = fr_re[i];
      in_imag[i*W +: W] = fr_im[i];
    end
  endtask

  task automatic push_exp();
    for (int k = 0; k < N; k++) begin
      q0.push_back('{re: fr_re[k], im: fr_im[k], idx: 4'(k), last: (k == N - 1)});
      q1.push_back('{re: fr_re[rev_order[k]], im: fr_im[rev_order[k]],
                     idx: 4'(rev_order[k]), last: (k == N - 1)});
    end
  endtask

  // Drive a frame and raise fft_done just after a rising edge.
  task automatic offer();
    tick();
    drive_frame();
    push_exp();
    fft_done = 1'b1;
  endtask

  task automatic wait_fd(input int budget, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (cycles < budget && !found) begin
      @(negedge clk);
      cycles++;
      if (frame_done0) found = 1'b1;
    end
    check("frame_done_seen", found, 1);
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int c;
    c = 0;
    while (c < budget && xfer0 < target) begin
      @(negedge clk);
      c++;
    end
    check("xfer_reached", xfer0 >= target, 1);
  endtask

  initial begin
    int cyc;
    bit found;
    int base;
    int fd_base;

    // Reset state.
    rst = 1'b0;
    repeat (3) tick();
    check("rst_outputs0", {m_valid0, m_last0, busy0, frame_done0, drop_err0, m_real0, m_imag0, m_index0}, '0);
    check("rst_outputs1", {m_valid1, m_last1, busy1, frame_done1, drop_err1, m_real1, m_imag1, m_index1}, '0);
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (2) tick();

    // Ramp frame, always ready: latency 1, 16 consecutive words, then pulse.
    load_ramp();
    offer();
    @(negedge clk);
    check("lat_not_early", m_valid0, 0);
    @(negedge clk);
    check("lat_first_valid", m_valid0, 1);
    check("lat_first_idx_rev", m_index1, 0);
    wait_fd(40, cyc);
    check("ramp_len_cycles", cyc, 16);
    check("ramp_valid_low", m_valid0, 0);
    check("ramp_q_empty", q0.size() + q1.size(), 0);
    @(negedge clk);
    check("ramp_fd_one_cycle", frame_done0, 0);
    // fft_done still high: no retrigger.
    repeat (5) tick();
    check("held_done_no_stream", busy0, 0);
    fft_done = 1'b0;

    // Random frame with ready pattern 1-0-0-1.
    load_rand();
    offer();
    tick();
    fft_done = 1'b0;
    for (int c = 0; c < 200 && !frame_done0; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
    end
    check("stall_frame_done", frame_done0, 1);
    check("stall_q_empty", q0.size() + q1.size(), 0);
    m_ready = 1'b1;
    tick();

    // Back-to-back: new frame offered exactly on the last-word transfer.
    load_ramp();
    offer();
    tick();
    fft_done = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (m_valid0 && m_last0) found = 1'b1;
    end
    check("b2b_saw_last", found, 1);
    load_const(16'h7FFF, 16'h8000);
    drive_frame();
    push_exp();
    fft_done = 1'b1;
    @(negedge clk);
    check("b2b_valid", m_valid0, 1);
    check("b2b_idx", m_index0, 0);
    check("b2b_idx_rev", m_index1, 0);
    check("b2b_data", {m_real0, m_imag0}, 32'h7FFF_8000);
    check("b2b_no_fd", frame_done0, 0);
    wait_fd(40, cyc);
    check("b2b_len_cycles", cyc, 16);
    check("b2b_q_empty", q0.size() + q1.size(), 0);
    check("b2b_no_drop", drop_err0, 0);
    tick();
    fft_done = 1'b0;
    tick();

    // Overlapping offer mid-frame: discarded, first frame intact.
    base = xfer0;
    load_rand();
    offer();
    tick();
    fft_done = 1'b0;
    wait_xfer(base + 5, 40);
    load_const(16'h1234, 16'h4321);
    drive_frame();
    fft_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drop_err_set0", drop_err0, 1);
    check("drop_err_set1", drop_err1, 1);
    wait_fd(40, cyc);
    check("drop_q_empty", q0.size() + q1.size(), 0);
    repeat (20) tick();
    check("drop_no_second", busy0, 0);
    check("drop_err_sticky", drop_err0, 1);

    // Reset mid-frame with fft_done held high.
    fft_done = 1'b0;
    tick();
    base = xfer0;
    load_ramp();
    offer();
    wait_xfer(base + 7, 40);
    fd_base = fd0;
    rst = 1'b0;
    #1;
    check("midrst_outputs0", {m_valid0, m_last0, busy0, frame_done0, drop_err0, m_real0, m_imag0, m_index0}, '0);
    check("midrst_outputs1", {m_valid1, m_last1, busy1, frame_done1, drop_err1, m_real1, m_imag1, m_index1}, '0);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("midrst_no_stream", busy0, 0);
    check("midrst_no_fd", fd0, fd_base);
    fft_done = 1'b0;
    tick();
    load_rand();
    offer();
    wait_fd(60, cyc);
    check("post_rst_q_empty", q0.size() + q1.size(), 0);
    fft_done = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
